// File: rtl/tdc_result_framer.sv
// tdc_result_framer
// Buffers TDC result words in a small FIFO and drains each one as a byte frame:
// header 0xA5, sequence number, then the result word MSB first, zero-padded to whole bytes.

module tdc_result_framer #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [DATA_W-1:0] iData,
    input  logic              iDone,
    input  logic              iClrOvf,
    input  logic              iByteReady,
    output logic [7:0]        oByte,
    output logic              oByteValid,
    output logic              oEmpty,
    output logic              oFull,
    output logic [ADDR_W:0]   oCount,
    output logic              oOverflow,
    output logic [7:0]        oDropCnt
);

    localparam int NB = (DATA_W + 7) / 8;
    localparam int SW = NB * 8;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        SEQ,
        DAT
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic [SW-1:0]     shreg;
    logic [SW-1:0]     shreg_shl;
    logic [SW-1:0]     head_ext;
    logic [7:0]        seq;
    logic [7:0]        bcnt;
    logic              pop;
    logic              push;
    logic              drop;
    logic              xfer;

    // Push/pop decisions for this edge; a full FIFO still takes a word if the head leaves on the same edge
    always_comb begin
        pop        = (state == IDLE) && (oCount != '0);
        push       = iDone && ((oCount < (ADDR_W+1)'(DEPTH)) || pop);
        drop       = iDone && !push;
        xfer       = oByteValid && iByteReady;
        count_next = oCount + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        head_ext   = '0;
        head_ext[DATA_W-1:0] = mem[rd_ptr];
        shreg_shl  = shreg << 8;
    end

    // Word storage; no reset needed because only slots covered by the count are ever read
    always_ff @(posedge iClk) begin
        if (push) begin
            mem[wr_ptr] <= iData;
        end
    end

    // Pointers and registered occupancy flags, reflecting the state after each edge
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            oCount <= '0;
            oEmpty <= 1'b1;
            oFull  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            oCount <= count_next;
            oEmpty <= (count_next == '0);
            oFull  <= (count_next == (ADDR_W+1)'(DEPTH));
        end
    end

    // Sticky overflow and saturating drop count; a drop on the clear edge wins and counts as the first drop
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oOverflow <= 1'b0;
            oDropCnt  <= '0;
        end else if (drop) begin
            oOverflow <= 1'b1;
            if (iClrOvf) begin
                oDropCnt <= 8'd1;
            end else if (oDropCnt != 8'hFF) begin
                oDropCnt <= oDropCnt + 8'd1;
            end
        end else if (iClrOvf) begin
            oOverflow <= 1'b0;
            oDropCnt  <= '0;
        end
    end

    // Frame sequencer; the next byte is staged in oByte so the stream output is fully registered
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state      <= IDLE;
            oByte      <= '0;
            oByteValid <= 1'b0;
            shreg      <= '0;
            seq        <= '0;
            bcnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg      <= head_ext;
                        oByte      <= 8'hA5;
                        oByteValid <= 1'b1;
                        state      <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        oByte <= seq;
                        state <= SEQ;
                    end
                end
                SEQ: begin
                    if (xfer) begin
                        seq   <= seq + 8'd1;
                        bcnt  <= '0;
                        oByte <= shreg[SW-1 -: 8];
                        state <= DAT;
                    end
                end
                DAT: begin
                    if (xfer) begin
                        shreg <= shreg_shl;
                        bcnt  <= bcnt + 8'd1;
                        if (bcnt == 8'(NB - 1)) begin
                            oByte      <= '0;
                            oByteValid <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            oByte <= shreg_shl[SW-1 -: 8];
                        end
                    end
                end
                default: begin
                    oByteValid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_result_framer.sv
// tb_tdc_result_framer
// Directed bench for tdc_result_framer. A queue-based model (word FIFO plus the byte list
// of the frame in flight) predicts every output each cycle; literal checks pin the model.

module tb_tdc_result_framer;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int NB     = 3;

    logic              iClk       = 1'b0;
    logic              iRst_n     = 1'b0;
    logic [DATA_W-1:0] iData      = '0;
    logic              iDone      = 1'b0;
    logic              iClrOvf    = 1'b0;
    logic              iByteReady = 1'b0;
    logic [7:0]        oByte;
    logic              oByteValid;
    logic              oEmpty;
    logic              oFull;
    logic [ADDR_W:0]   oCount;
    logic              oOverflow;
    logic [7:0]        oDropCnt;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] mq[$];
    logic [7:0]        mf[$];
    logic [7:0]        m_seq;
    logic              m_ovf;
    logic [7:0]        m_drop;

    logic [7:0] rx[$];
    int         peak_cnt   = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = '0;

    always #5 iClk = ~iClk;

    tdc_result_framer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iData     (iData),
        .iDone     (iDone),
        .iClrOvf   (iClrOvf),
        .iByteReady(iByteReady),
        .oByte     (oByte),
        .oByteValid(oByteValid),
        .oEmpty    (oEmpty),
        .oFull     (oFull),
        .oCount    (oCount),
        .oOverflow (oOverflow),
        .oDropCnt  (oDropCnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic done, input logic [DATA_W-1:0] data,
                                 input logic ready, input logic clr);
        @(posedge iClk);
        #2;
        iDone      = done;
        iData      = data;
        iByteReady = ready;
        iClrOvf    = clr;
    endtask

    task automatic doReset();
        @(posedge iClk);
        #2;
        iRst_n     = 1'b0;
        iDone      = 1'b0;
        iData      = '0;
        iByteReady = 1'b0;
        iClrOvf    = 1'b0;
        repeat (2) @(posedge iClk);
        #2;
        iRst_n   = 1'b1;
        rx.delete();
        peak_cnt = 0;
    endtask

    task automatic waitBytes(input int n, input int budget, input string name);
        int k = 0;
        while (int'(rx.size()) < n && k < budget) begin
            @(posedge iClk);
            k++;
        end
        checkOutput(name, 32'(int'(rx.size()) >= n), 32'd1);
    endtask

    function automatic logic [31:0] rxAt(input int i);
        if (i < int'(rx.size())) begin
            return {24'h0, rx[i]};
        end
        return 32'hDEAD;
    endfunction

    // Transaction-level model: the frame in flight is a byte list, the FIFO a word queue
    always @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            mq.delete();
            mf.delete();
            m_seq  = 8'h00;
            m_ovf  = 1'b0;
            m_drop = 8'h00;
        end else begin
            logic              start;
            logic              accept;
            logic [DATA_W-1:0] w;
            start  = (mf.size() == 0) && (mq.size() != 0);
            if (mf.size() != 0 && iByteReady) begin
                void'(mf.pop_front());
            end
            accept = iDone && ((int'(mq.size()) < DEPTH) || start);
            if (start) begin
                w = mq.pop_front();
                mf.push_back(8'hA5);
                mf.push_back(m_seq);
                for (int b = NB - 1; b >= 0; b--) begin
                    mf.push_back(8'(w >> (8 * b)));
                end
                m_seq = m_seq + 8'd1;
            end
            if (accept) begin
                mq.push_back(iData);
            end
            if (iDone && !accept) begin
                m_ovf  = 1'b1;
                m_drop = iClrOvf ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
            end else if (iClrOvf) begin
                m_ovf  = 1'b0;
                m_drop = 8'h00;
            end
        end
    end

    // Per-cycle comparison against the model, plus byte capture and hold-under-stall checks
    always @(negedge iClk) begin
        checkOutput("valid",    {31'h0, oByteValid}, {31'h0, mf.size() != 0});
        checkOutput("byte",     {24'h0, oByte},      (mf.size() != 0) ? {24'h0, mf[0]} : 32'h0);
        checkOutput("count",    {27'h0, oCount},     32'(mq.size()));
        checkOutput("empty",    {31'h0, oEmpty},     {31'h0, mq.size() == 0});
        checkOutput("full",     {31'h0, oFull},      {31'h0, int'(mq.size()) == DEPTH});
        checkOutput("overflow", {31'h0, oOverflow},  {31'h0, m_ovf});
        checkOutput("dropcnt",  {24'h0, oDropCnt},   {24'h0, m_drop});
        if (iRst_n && prev_stall) begin
            checkOutput("stall_hold_byte",  {24'h0, oByte}, {24'h0, prev_byte});
            checkOutput("stall_hold_valid", {31'h0, oByteValid}, 32'd1);
        end
        prev_stall = iRst_n && oByteValid && !iByteReady;
        prev_byte  = oByte;
        if (iRst_n && oByteValid && iByteReady) begin
            rx.push_back(oByte);
        end
        if (int'(oCount) > peak_cnt) begin
            peak_cnt = int'(oCount);
        end
    end

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        logic [7:0] exp1 [5];
        int k;
        exp1 = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56};

        // Single word, ready held high
        doReset();
        checkOutput("rst_empty", {31'h0, oEmpty}, 32'd1);
        checkOutput("rst_count", {27'h0, oCount}, 32'd0);
        applyStimulus(1'b1, 24'h123456, 1'b1, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        @(negedge iClk);
        checkOutput("t1_hdr_not_yet", {31'h0, oByteValid}, 32'd0);
        checkOutput("t1_count_one", {27'h0, oCount}, 32'd1);
        @(negedge iClk);
        checkOutput("t1_hdr_valid", {31'h0, oByteValid}, 32'd1);
        checkOutput("t1_hdr_byte", {24'h0, oByte}, 32'hA5);
        checkOutput("t1_empty_after_pop", {31'h0, oEmpty}, 32'd1);
        waitBytes(5, 40, "t1_frame_done");
        for (int i = 0; i < 5; i++) begin
            checkOutput("t1_frame_byte", rxAt(i), {24'h0, exp1[i]});
        end

        // Same word with ready toggling every cycle
        doReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(i == 0, 24'h123456, (i % 2) == 1, 1'b0);
        end
        checkOutput("t2_byte_total", 32'(rx.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_frame_byte", rxAt(i), {24'h0, exp1[i]});
        end

        // Fill with ready low until a word is dropped, then drain
        doReset();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 24'hC00000 | 24'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        @(negedge iClk);
        checkOutput("t3_peak_count", 32'(peak_cnt), 32'd16);
        checkOutput("t3_full", {31'h0, oFull}, 32'd1);
        checkOutput("t3_dropcnt", {24'h0, oDropCnt}, 32'd1);
        checkOutput("t3_overflow", {31'h0, oOverflow}, 32'd1);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        waitBytes(85, 200, "t3_drain_done");
        repeat (10) applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        checkOutput("t3_byte_total", 32'(rx.size()), 32'd85);
        for (int f = 0; f < 17; f++) begin
            checkOutput("t3_hdr", rxAt(5 * f), 32'hA5);
            checkOutput("t3_seq", rxAt(5 * f + 1), 32'(f));
            checkOutput("t3_msb", rxAt(5 * f + 2), 32'hC0);
            checkOutput("t3_lsb", rxAt(5 * f + 4), 32'(f));
        end
        checkOutput("t3_empty_end", {31'h0, oEmpty}, 32'd1);

        // Full FIFO, sequencer back in idle, push on the pop edge
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 24'hD00000 | 24'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        @(negedge iClk);
        checkOutput("t4_full_before", {27'h0, oCount}, 32'd16);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        k = 0;
        @(negedge iClk);
        while (oByteValid && k < 30) begin
            @(negedge iClk);
            k++;
        end
        checkOutput("t4_idle_reached", {31'h0, oByteValid}, 32'd0);
        iDone      = 1'b1;
        iData      = 24'hDDDDDD;
        iByteReady = 1'b0;
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        @(negedge iClk);
        checkOutput("t4_count_stays", {27'h0, oCount}, 32'd16);
        checkOutput("t4_no_drop", {24'h0, oDropCnt}, 32'd0);
        checkOutput("t4_no_overflow", {31'h0, oOverflow}, 32'd0);
        checkOutput("t4_hdr_started", {24'h0, oByte}, 32'hA5);

        // 257 frames to wrap the sequence number, then clear-versus-drop
        doReset();
        for (int f = 0; f < 257; f++) begin
            applyStimulus(1'b1, 24'hE00000 | 24'(f), 1'b1, 1'b0);
            repeat (5) applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        end
        waitBytes(1285, 100, "t5_frames_done");
        checkOutput("t5_seq_first", rxAt(1), 32'h00);
        checkOutput("t5_seq_ff", rxAt(5 * 255 + 1), 32'hFF);
        checkOutput("t5_seq_wrap", rxAt(5 * 256 + 1), 32'h00);
        checkOutput("t5_last_mid", rxAt(5 * 256 + 3), 32'h01);
        checkOutput("t5_last_lsb", rxAt(5 * 256 + 4), 32'h00);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b1, 24'hF00000 | 24'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        @(negedge iClk);
        checkOutput("t5_two_drops", {24'h0, oDropCnt}, 32'd2);
        applyStimulus(1'b1, 24'hF0F0F0, 1'b0, 1'b1);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        @(negedge iClk);
        checkOutput("t5_clr_drop_ovf", {31'h0, oOverflow}, 32'd1);
        checkOutput("t5_clr_drop_cnt", {24'h0, oDropCnt}, 32'd1);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        @(negedge iClk);
        checkOutput("t5_clr_ovf", {31'h0, oOverflow}, 32'd0);
        checkOutput("t5_clr_cnt", {24'h0, oDropCnt}, 32'd0);

        // Asynchronous reset while the second data byte is on the bus
        doReset();
        applyStimulus(1'b1, 24'h123456, 1'b1, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        k = 0;
        @(negedge iClk);
        while (!(oByteValid && oByte == 8'h34) && k < 20) begin
            @(negedge iClk);
            k++;
        end
        checkOutput("t6_reached_dat2", {24'h0, oByte}, 32'h34);
        #1;
        iRst_n = 1'b0;
        #1;
        checkOutput("t6_valid_drops", {31'h0, oByteValid}, 32'd0);
        checkOutput("t6_byte_zero", {24'h0, oByte}, 32'd0);
        checkOutput("t6_count_zero", {27'h0, oCount}, 32'd0);
        checkOutput("t6_empty", {31'h0, oEmpty}, 32'd1);
        @(posedge iClk);
        #2;
        iRst_n = 1'b1;
        rx.delete();
        applyStimulus(1'b1, 24'hABCDEF, 1'b1, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        waitBytes(5, 40, "t6_frame_done");
        checkOutput("t6_hdr", rxAt(0), 32'hA5);
        checkOutput("t6_seq_restart", rxAt(1), 32'h00);
        checkOutput("t6_msb", rxAt(2), 32'hAB);
        checkOutput("t6_lsb", rxAt(4), 32'hEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
